multichannel_clock_divider: RTL and testbench

Programmable multi-channel clock-enable / divided-clock generator for the image-processing pipeline. Each of `CHANNELS` independent channels divides `input_clock` by a runtime-programmable ratio with programmable high time, producing a registered divided clock level and a one-cycle clock-enable strobe. Downstream logic uses the strobes as clock enables. Divisor changes take effect glitch-free at period boundaries.

---
 rtl/multichannel_clock_divider.sv | 63 ++++++
 tb/tb_multichannel_clock_divider.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multichannel_clock_divider.sv
// multichannel_clock_divider: per-channel programmable divided clock and enable strobe
// with shadowed ratio updates applied only at period boundaries
module multichannel_clock_divider #(
  parameter int CHANNELS         = 4,
  parameter int COUNTER_WIDTH    = 16,
  parameter int DEFAULT_DIVISION = 2
) (
  input  logic                     input_clock,
  input  logic                     reset,
  input  logic [CHANNELS-1:0]      enable,
  input  logic                     config_valid,
  input  logic [3:0]               channel_select,
  input  logic [COUNTER_WIDTH-1:0] division_value,
  input  logic [COUNTER_WIDTH-1:0] high_cycles,
  output logic [CHANNELS-1:0]      output_clock,
  output logic [CHANNELS-1:0]      clock_enable,
  output logic [CHANNELS-1:0]      pending,
  output logic                     config_error
);
  localparam int CW = COUNTER_WIDTH;
  localparam logic [CW-1:0] DEF_N = CW'(DEFAULT_DIVISION);
  localparam logic [CW-1:0] DEF_H = CW'(DEFAULT_DIVISION / 2);
  localparam logic [CW-1:0] ONE = CW'(1);
  logic sel_ok;
  logic err_q;
  assign sel_ok = {1'b0, channel_select} < 5'(CHANNELS);
  assign config_error = err_q;
  always_ff @(posedge input_clock)
    err_q <= reset ? 1'b0 : config_valid && !sel_ok;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [CW-1:0] n_q, h_q, sn_q, sh_q, cnt_q, cnt_d;
    logic pend_q, oc_q, ce_q, wr, run, last, apply;
    assign wr = config_valid && sel_ok && channel_select == 4'(g);
    assign run = enable[g] && n_q != '0;
    assign last = cnt_q == n_q - ONE;
    // a disabled or degenerate (N<=1) channel has no period to protect, so swap immediately
    assign apply = pend_q && (last || !enable[g] || n_q <= ONE);
    assign cnt_d = (!run || apply || last) ? '0 : cnt_q + ONE;
    assign output_clock[g] = oc_q;
    assign clock_enable[g] = ce_q;
    assign pending[g] = pend_q;
    always_ff @(posedge input_clock)
      if (reset) begin
        n_q    <= DEF_N;
        h_q    <= DEF_H;
        sn_q   <= DEF_N;
        sh_q   <= DEF_H;
        cnt_q  <= '0;
        pend_q <= 1'b0;
        oc_q   <= 1'b0;
        ce_q   <= 1'b0;
      end else begin
        oc_q   <= run && cnt_q < h_q;
        ce_q   <= run && cnt_q == '0;
        cnt_q  <= cnt_d;
        n_q    <= apply ? sn_q : n_q;
        h_q    <= apply ? sh_q : h_q;
        sn_q   <= wr ? division_value : sn_q;
        sh_q   <= wr ? high_cycles : sh_q;
        pend_q <= wr || (pend_q && !apply);
      end
  end
endmodule

// File: tb/tb_multichannel_clock_divider.sv
// tb_multichannel_clock_divider: directed scoreboard bench for the multichannel divider
module tb_multichannel_clock_divider;
  logic        input_clock = 1'b0;
  logic        reset;
  logic [3:0]  enable;
  logic        config_valid;
  logic [3:0]  channel_select;
  logic [15:0] division_value;
  logic [15:0] high_cycles;
  logic [3:0]  output_clock;
  logic [3:0]  clock_enable;
  logic [3:0]  pending;
  logic        config_error;

  typedef struct {
    string      tag;
    logic [3:0] oc;
    logic [3:0] ce;
    logic [3:0] pd;
    logic       er;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  multichannel_clock_divider #(
    .CHANNELS(4), .COUNTER_WIDTH(16), .DEFAULT_DIVISION(2)
  ) dut (
    .input_clock(input_clock),
    .reset(reset),
    .enable(enable),
    .config_valid(config_valid),
    .channel_select(channel_select),
    .division_value(division_value),
    .high_cycles(high_cycles),
    .output_clock(output_clock),
    .clock_enable(clock_enable),
    .pending(pending),
    .config_error(config_error)
  );

  always #5 input_clock = ~input_clock;

  task automatic wr(input int ch, input int n, input int h);
    config_valid   = 1'b1;
    channel_select = 4'(ch);
    division_value = 16'(n);
    high_cycles    = 16'(h);
  endtask

  task automatic step(input string tag, input logic [3:0] oc, input logic [3:0] ce,
                      input logic [3:0] pd, input logic er = 1'b0);
    exp_t e;
    e.tag = tag;
    e.oc  = oc;
    e.ce  = ce;
    e.pd  = pd;
    e.er  = er;
    sb.push_back(e);
    @(posedge input_clock);
    #1;
    config_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    assert (output_clock === e.oc) else begin
      errors++;
      $error("FAIL %s output_clock got %b exp %b", e.tag, output_clock, e.oc);
    end
    checks++;
    assert (clock_enable === e.ce) else begin
      errors++;
      $error("FAIL %s clock_enable got %b exp %b", e.tag, clock_enable, e.ce);
    end
    checks++;
    assert (pending === e.pd) else begin
      errors++;
      $error("FAIL %s pending got %b exp %b", e.tag, pending, e.pd);
    end
    checks++;
    assert (config_error === e.er) else begin
      errors++;
      $error("FAIL %s config_error got %b exp %b", e.tag, config_error, e.er);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 4'hf;
    config_valid = 1'b0;
    channel_select = '0;
    division_value = '0;
    high_cycles = '0;
    step("rst0", 4'h0, 4'h0, 4'h0);
    step("rst1", 4'h0, 4'h0, 4'h0);
    reset = 1'b0;
    enable = 4'h0;
    step("idle", 4'h0, 4'h0, 4'h0);

    // ch0 N=4 H=2, then drop enable mid-period
    wr(0, 4, 2);
    step("ch0_wr", 4'h0, 4'h0, 4'b0001);
    step("ch0_ap", 4'h0, 4'h0, 4'h0);
    enable = 4'b0001;
    for (int i = 0; i < 6; i++)
      step("ch0_run", (i % 4 < 2) ? 4'b0001 : 4'h0, (i % 4 == 0) ? 4'b0001 : 4'h0, 4'h0);
    enable = 4'h0;
    step("ch0_drop", 4'h0, 4'h0, 4'h0);

    // ch1 N=3 H=1, retarget to N=5 H=3 at counter 0
    wr(1, 3, 1);
    step("ch1_wr", 4'h0, 4'h0, 4'b0010);
    step("ch1_ap", 4'h0, 4'h0, 4'h0);
    enable = 4'b0010;
    step("ch1_o0", 4'b0010, 4'b0010, 4'h0);
    step("ch1_o1", 4'h0, 4'h0, 4'h0);
    step("ch1_o2", 4'h0, 4'h0, 4'h0);
    wr(1, 5, 3);
    step("ch1_o0w", 4'b0010, 4'b0010, 4'b0010);
    step("ch1_o1p", 4'h0, 4'h0, 4'b0010);
    step("ch1_o2a", 4'h0, 4'h0, 4'h0);
    step("ch1_n0", 4'b0010, 4'b0010, 4'h0);
    step("ch1_n1", 4'b0010, 4'h0, 4'h0);
    step("ch1_n2", 4'b0010, 4'h0, 4'h0);
    step("ch1_n3", 4'h0, 4'h0, 4'h0);
    step("ch1_n4", 4'h0, 4'h0, 4'h0);
    step("ch1_n5", 4'b0010, 4'b0010, 4'h0);
    enable = 4'h0;
    step("ch1_off", 4'h0, 4'h0, 4'h0);

    // ch2 H=0 N=4, last-write-wins, write during apply, N=1 and N=0
    wr(2, 4, 0);
    step("ch2_wr", 4'h0, 4'h0, 4'b0100);
    step("ch2_ap", 4'h0, 4'h0, 4'h0);
    enable = 4'b0100;
    for (int i = 0; i < 8; i++)
      step("ch2_h0", 4'h0, (i % 4 == 0) ? 4'b0100 : 4'h0, 4'h0);
    wr(2, 7, 7);
    step("ch2_w77", 4'h0, 4'b0100, 4'b0100);
    wr(2, 1, 1);
    step("ch2_w11", 4'h0, 4'h0, 4'b0100);
    step("ch2_c2", 4'h0, 4'h0, 4'b0100);
    wr(2, 0, 0);
    step("ch2_wap", 4'h0, 4'h0, 4'b0100);
    step("ch2_n1", 4'b0100, 4'b0100, 4'h0);
    step("ch2_n0a", 4'h0, 4'h0, 4'h0);
    step("ch2_n0b", 4'h0, 4'h0, 4'h0);
    wr(2, 1, 1);
    step("ch2_w1", 4'h0, 4'h0, 4'b0100);
    step("ch2_ap1", 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++)
      step("ch2_n1c", 4'b0100, 4'b0100, 4'h0);
    enable = 4'h0;
    step("ch2_off", 4'h0, 4'h0, 4'h0);

    // out-of-range select
    wr(4, 9, 9);
    step("cfg_err", 4'h0, 4'h0, 4'h0, 1'b1);
    step("err_clr", 4'h0, 4'h0, 4'h0, 1'b0);

    // ch0 and ch3 N=6 phase-aligned, then reset with a pending write
    wr(0, 6, 3);
    step("pa_wr0", 4'h0, 4'h0, 4'b0001);
    wr(3, 6, 3);
    step("pa_wr3", 4'h0, 4'h0, 4'b1000);
    step("pa_ap", 4'h0, 4'h0, 4'h0);
    enable = 4'b1001;
    for (int i = 0; i < 14; i++)
      step("pa_run", (i % 6 < 3) ? 4'b1001 : 4'h0, (i % 6 == 0) ? 4'b1001 : 4'h0, 4'h0);
    wr(0, 3, 1);
    step("rm_wr", 4'b1001, 4'h0, 4'b0001);
    reset = 1'b1;
    step("rm_rst", 4'h0, 4'h0, 4'h0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      step("rm_def", (i % 2 == 0) ? 4'b1001 : 4'h0, (i % 2 == 0) ? 4'b1001 : 4'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
